// File: rtl/mem_interface.sv
// Line mover: pops a BURST_LEN-word burst from an FWFT read FIFO
// and pushes it, in order, into a write FIFO one cycle later.
module mem_interface #(
  parameter int DATA_WIDTH = 12,
  parameter int FILL_WIDTH = 10,
  parameter int BURST_LEN  = 640
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_req,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [FILL_WIDTH-1:0] i_rfill,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic             pop;

  // Pop only while a burst has words left, data is present and
  // downstream has room; reset and flush force the strobe low so
  // no word can leave the read FIFO without being pushed.
  assign pop = i_rstn && !i_flush
            && (state == ACTIVE)
            && (rem != '0)
            && (i_rfill != '0)
            && !i_almostfull;

  assign o_rd = pop;

  // Next-state and remaining-count logic.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    unique case (state)
      IDLE: begin
        if (i_req) begin
          state_nxt = ACTIVE;
          rem_nxt   = BURST;
        end
      end
      ACTIVE: begin
        if (pop) begin
          rem_nxt = rem - ONE;
          if (rem == ONE) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = '0;
      end
    endcase
  end

  // State register; flush behaves like reset for the burst control.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      rem   <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // One-cycle write pipeline: the popped head word is pushed on the
  // following cycle; o_wdata holds between pushes.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_wr    <= 1'b0;
      o_wdata <= '0;
    end else if (i_flush) begin
      o_wr    <= 1'b0;
    end else begin
      o_wr <= pop;
      if (pop) begin
        o_wdata <= i_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: FIFO model on the read side,
// cycle-level reference model checked with immediate assertions.
module tb_mem_interface;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        req;
  logic        rd;
  logic [11:0] rdata;
  logic [9:0]  rfill;
  logic        wr;
  logic [11:0] wdata;
  logic        af;

  int checks;
  int errors;

  int fifo_cnt;
  bit stall;

  bit   m_active;
  int   m_rem;
  bit   m_wr;
  int   m_wdata;
  bit   prev_af;
  int   pops;
  int   pushes;
  int   last_w;
  bit   popped;
  bit   exp_rd;

  mem_interface dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_flush      (flush),
    .i_req        (req),
    .o_rd         (rd),
    .i_rdata      (rdata),
    .i_rfill      (rfill),
    .o_wr         (wr),
    .o_wdata      (wdata),
    .i_almostfull (af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // FIFO head holds value fifo_cnt; contents are fifo_cnt..1.
  task automatic upd_fifo();
    rdata = 12'(fifo_cnt);
    if (stall)
      rfill = '0;
    else if (fifo_cnt > 1023)
      rfill = 10'd1023;
    else
      rfill = 10'(fifo_cnt);
  endtask

  task automatic refill(input int n);
    fifo_cnt = n;
    last_w   = 0;
    pops     = 0;
    pushes   = 0;
    upd_fifo();
  endtask

  // One clock: check at negedge, advance model, then move the FIFO.
  task automatic tick();
    @(negedge clk);
    exp_rd = m_active && (m_rem != 0) && (rfill != 0)
          && !af && rstn && !flush;
    chk("rd", {31'd0, rd}, {31'd0, exp_rd});
    chk("wr", {31'd0, wr}, {31'd0, m_wr});
    if (m_wr) begin
      chk("wdata", {20'd0, wdata}, m_wdata);
    end
    if (wr === 1'b1) begin
      chk("af_prev", {31'd0, prev_af}, 0);
      if (last_w > 0)
        chk("order", {20'd0, wdata}, last_w - 1);
      last_w = int'(wdata);
      pushes++;
    end
    popped = (rd === 1'b1);
    if (popped) pops++;
    if (!rstn || flush) begin
      m_active = 1'b0;
      m_rem    = 0;
      m_wr     = 1'b0;
      if (!rstn) m_wdata = 0;
    end else begin
      m_wr = exp_rd;
      if (exp_rd) m_wdata = int'(rdata);
      if (m_active) begin
        if (exp_rd) begin
          m_rem--;
          if (m_rem == 0) m_active = 1'b0;
        end
      end else if (req) begin
        m_active = 1'b1;
        m_rem    = 640;
      end
    end
    prev_af = af;
    @(posedge clk);
    #1;
    if (popped) fifo_cnt--;
    upd_fifo();
  endtask

  task automatic finish_burst(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!m_active && !m_wr) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_active = 1'b0;
    m_rem    = 0;
    m_wr     = 1'b0;
    m_wdata  = 0;
    prev_af  = 1'b0;
    stall    = 1'b0;
    rstn     = 1'b0;
    flush    = 1'b0;
    req      = 1'b0;
    af       = 1'b0;
    refill(640);

    repeat (2) @(posedge clk);
    #1;
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_wr", {31'd0, wr}, 0);
    chk("rst_wdata", {20'd0, wdata}, 0);

    // Idle: full read FIFO but no request.
    repeat (1000) tick();
    chk("idle_pops", pops, 0);

    // Plain burst of 640 words, values 640..1.
    pulse_req();
    finish_burst("b1");
    chk("b1_pops", pops, 640);
    chk("b1_push", pushes, 640);
    chk("b1_last", last_w, 1);
    repeat (20) tick();
    chk("b1_after", pops, 640);

    // Almost-full held 6 cycles; stray request mid-burst ignored.
    refill(640);
    pulse_req();
    repeat (100) tick();
    af = 1'b1;
    repeat (6) tick();
    af = 1'b0;
    pulse_req();
    finish_burst("b2");
    chk("b2_pops", pops, 640);
    chk("b2_last", last_w, 1);

    // Almost-full toggling every 2 cycles.
    refill(640);
    pulse_req();
    for (int i = 0; i < 600; i++) begin
      af = ((i / 2) % 2) == 1;
      tick();
    end
    af = 1'b0;
    finish_burst("b3");
    chk("b3_pops", pops, 640);
    chk("b3_push", pushes, 640);

    // Empty read FIFO stall after 100 words.
    refill(640);
    pulse_req();
    for (int i = 0; i < 400 && pops < 100; i++) tick();
    chk("b4_at100", pops, 100);
    stall = 1'b1;
    upd_fifo();
    repeat (20) tick();
    chk("b4_stall", pops, 100);
    chk("b4_active", {31'd0, m_active}, 1);
    stall = 1'b0;
    upd_fifo();
    finish_burst("b4");
    chk("b4_pops", pops, 640);

    // Flush mid-burst together with a request: flush wins.
    refill(640);
    pulse_req();
    repeat (50) tick();
    flush = 1'b1;
    req   = 1'b1;
    tick();
    flush = 1'b0;
    req   = 1'b0;
    repeat (30) tick();
    chk("b5_flushed", pops, 50);
    chk("b5_idle", {31'd0, m_active}, 0);
    refill(640);
    pulse_req();
    finish_burst("b5");
    chk("b5_pops", pops, 640);

    // Back-to-back: request in the cycle of the last push.
    refill(1280);
    pulse_req();
    for (int i = 0; i < 2000 && m_active; i++) tick();
    chk("b6_first", pops, 640);
    chk("b6_lastwr", {31'd0, m_wr}, 1);
    pulse_req();
    finish_burst("b6");
    chk("b6_pops", pops, 1280);
    chk("b6_last", last_w, 1);

    // Reset mid-burst acts like flush.
    refill(640);
    pulse_req();
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    chk("b7_pops", pops, 10);
    chk("b7_wdata", {20'd0, wdata}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
